// File: rtl/data_bus_responder.sv
// Memory-side responder for the CPU data bus: one request at a time, configurable wait states,
// byte/half/word stores with lane merging and sign/zero-extended loads from a local word RAM.
module data_bus_responder #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  funct3,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic        busy
);

  localparam int unsigned Depth    = 2 ** ADDR_WIDTH;
  localparam logic [32:0] Span     = 33'(Depth) << 2;
  localparam logic [3:0]  WaitLast = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StWait, StAccess, StResp} state_e;

  state_e                  state_q;
  logic [3:0]              cnt_q;
  logic                    we_q;
  logic                    fault_q;
  logic [1:0]              lane_q;
  logic [ADDR_WIDTH-1:0]   idx_q;
  logic [31:0]             wdata_q;
  logic [2:0]              funct3_q;
  logic [31:0]             rdata_q;
  logic                    ready_q;
  logic                    err_q;

  logic [31:0] mem [Depth];

  logic [32:0] offset;
  logic        req_err;
  logic [31:0] rd_word, rd_shift, wide_wdata, wr_word, load_data;
  logic [15:0] half_sel;
  logic [3:0]  be;

  // Decode of the incoming request; only meaningful in the cycle it is accepted.
  always_comb begin
    offset  = {1'b0, addr} - {1'b0, BASE_ADDR};
    req_err = 1'b0;
    case (funct3)
      3'b000, 3'b100: req_err = 1'b0;
      3'b001, 3'b101: req_err = addr[0];
      3'b010:         req_err = (addr[1:0] != 2'b00);
      default:        req_err = 1'b1;
    endcase
    if (we && funct3[2]) req_err = 1'b1;
    if ((addr < BASE_ADDR) || (offset >= Span)) req_err = 1'b1;
  end

  // Store lane merge and load extraction on the addressed word.
  always_comb begin
    rd_word    = mem[idx_q];
    be         = 4'b1111;
    wide_wdata = wdata_q;
    unique case (funct3_q[1:0])
      2'b00: begin
        be         = 4'b0001 << lane_q;
        wide_wdata = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be         = lane_q[1] ? 4'b1100 : 4'b0011;
        wide_wdata = {2{wdata_q[15:0]}};
      end
      default: begin
        be         = 4'b1111;
        wide_wdata = wdata_q;
      end
    endcase
    wr_word = rd_word;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) wr_word[8*b +: 8] = wide_wdata[8*b +: 8];
    end

    rd_shift = rd_word >> {lane_q, 3'b000};
    half_sel = lane_q[1] ? rd_word[31:16] : rd_word[15:0];
    case (funct3_q)
      3'b000:  load_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_data = {24'h0, rd_shift[7:0]};
      3'b101:  load_data = {16'h0, half_sel};
      default: load_data = rd_word;
    endcase
  end

  // RAM is not reset; an aborted request never reaches StAccess so it never writes.
  always_ff @(posedge clk) begin
    if (state_q == StAccess && we_q && !fault_q) mem[idx_q] <= wr_word;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      fault_q  <= 1'b0;
      lane_q   <= '0;
      idx_q    <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
      rdata_q  <= '0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req) begin
            we_q     <= we;
            fault_q  <= req_err;
            lane_q   <= addr[1:0];
            idx_q    <= offset[ADDR_WIDTH+1:2];
            wdata_q  <= wdata;
            funct3_q <= funct3;
            cnt_q    <= '0;
            state_q  <= (WAIT_CYCLES > 0) ? StWait : StAccess;
          end
        end
        StWait: begin
          if (cnt_q == WaitLast) begin
            cnt_q   <= '0;
            state_q <= StAccess;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        StAccess: begin
          ready_q <= 1'b1;
          err_q   <= fault_q;
          rdata_q <= (fault_q || we_q) ? 32'h0 : load_data;
          state_q <= StResp;
        end
        StResp: begin
          ready_q <= 1'b0;
          err_q   <= 1'b0;
          rdata_q <= '0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rdata = rdata_q;
  assign ready = ready_q;
  assign err   = err_q;
  assign busy  = (state_q != StIdle);

endmodule

// File: tb/tb_data_bus_responder.sv
// Bench for data_bus_responder: latency on three wait settings, directed vector table,
// busy/reset corner sequences and randomized traffic against a byte-level memory model.
module tb_data_bus_responder;

  localparam logic [31:0] Base = 32'h1000_0000;
  localparam int          Span = 1024;

  logic        clk = 1'b0;
  logic        rst, req, we;
  logic [31:0] addr, wdata;
  logic [2:0]  funct3;
  logic [31:0] rdata0, rdata1, rdata3;
  logic        ready0, ready1, ready3, err0, err1, err3, busy0, busy1, busy3;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem_b [Span];

  always #5 clk = ~clk;

  data_bus_responder #(.ADDR_WIDTH(8), .BASE_ADDR(Base), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata), .funct3(funct3),
    .rdata(rdata1), .ready(ready1), .err(err1), .busy(busy1)
  );
  data_bus_responder #(.ADDR_WIDTH(8), .BASE_ADDR(Base), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata), .funct3(funct3),
    .rdata(rdata0), .ready(ready0), .err(err0), .busy(busy0)
  );
  data_bus_responder #(.ADDR_WIDTH(8), .BASE_ADDR(Base), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata), .funct3(funct3),
    .rdata(rdata3), .ready(ready3), .err(err3), .busy(busy3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One request on the shared inputs; reports dut1's response and cycles from accept to ready.
  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [2:0] f, output logic [31:0] rd, output logic e, output int lat);
    rd = '0; e = 1'b0; lat = -1;
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d; funct3 = f;
    @(negedge clk);
    req = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (ready1) begin
        lat = k; rd = rdata1; e = err1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Reference: byte-addressed memory, responses derived from access size and legality rules.
  function automatic void model(input logic w, input logic [31:0] a, input logic [31:0] d,
                                input logic [2:0] f, output logic [31:0] rd, output logic e);
    int size, off;
    logic [31:0] v;
    size = (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : 4;
    e = (f == 3'd3) || (f >= 3'd6) || (w && f[2]) || ((a % size) != 0) ||
        (a < Base) || (a >= Base + 32'(Span));
    rd = '0;
    if (!e) begin
      off = int'(a - Base);
      if (w) begin
        for (int b = 0; b < size; b++) mem_b[off + b] = d[8*b +: 8];
      end else begin
        v = '0;
        for (int b = 0; b < size; b++) v = v | (32'(mem_b[off + b]) << (8 * b));
        if (!f[2] && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8 * size));
        rd = v;
      end
    end
  endfunction

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [2:0]  f;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vt[32];
  int   nv = 0;

  task automatic add(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [2:0] f, input logic [31:0] r, input logic e);
    vt[nv] = '{w, a, d, f, r, e};
    nv++;
  endtask

  initial begin
    logic [31:0] rd, exp_rd, a, d;
    logic        e, exp_e, w;
    logic [2:0]  f;
    int          lat, nready, sz;

    rst = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; funct3 = '0;
    #2;
    chk("reset_rdata", rdata1, 32'h0);
    chk("reset_ready", 32'(ready1), 32'h0);
    chk("reset_err", 32'(err1), 32'h0);
    chk("reset_busy", 32'(busy1), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Latency/busy on all three wait settings from a common cycle 0.
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = Base; wdata = 32'h0; funct3 = 3'b010;
    @(negedge clk);
    req = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      chk($sformatf("w0_ready_c%0d", k), 32'(ready0), 32'(k == 2));
      chk($sformatf("w0_busy_c%0d", k), 32'(busy0), 32'(k <= 2));
      chk($sformatf("w1_ready_c%0d", k), 32'(ready1), 32'(k == 3));
      chk($sformatf("w3_ready_c%0d", k), 32'(ready3), 32'(k == 5));
      chk($sformatf("w3_busy_c%0d", k), 32'(busy3), 32'(k <= 5));
      chk($sformatf("w03_err_c%0d", k), 32'({err0, err3}), 32'h0);
      chk($sformatf("w03_rdata_c%0d", k), rdata0 | rdata3, 32'h0);
      @(negedge clk);
    end

    add(1, 32'h1000_0004, 32'hDEAD_BEEF, 3'b010, 32'h0,         0);
    add(0, 32'h1000_0004, 32'h0,         3'b010, 32'hDEAD_BEEF, 0);
    add(1, 32'h1000_0007, 32'h0000_0080, 3'b000, 32'h0,         0);
    add(0, 32'h1000_0004, 32'h0,         3'b010, 32'h80AD_BEEF, 0);
    add(0, 32'h1000_0007, 32'h0,         3'b000, 32'hFFFF_FF80, 0);
    add(0, 32'h1000_0007, 32'h0,         3'b100, 32'h0000_0080, 0);
    add(0, 32'h1000_0006, 32'h0,         3'b001, 32'hFFFF_80AD, 0);
    add(0, 32'h1000_0006, 32'h0,         3'b010, 32'h0,         1);
    add(1, 32'h1000_0000, 32'h0BAD_F00D, 3'b010, 32'h0,         0);
    add(1, 32'h1000_0402, 32'h1111_1111, 3'b010, 32'h0,         1);
    add(0, 32'h1000_0000, 32'h0,         3'b010, 32'h0BAD_F00D, 0);
    add(1, 32'h1000_0008, 32'hCAFE_F00D, 3'b010, 32'h0,         0);
    add(1, 32'h1000_0008, 32'h9999_9999, 3'b100, 32'h0,         1);
    add(1, 32'h1000_000A, 32'h0000_1234, 3'b001, 32'h0,         0);
    add(0, 32'h1000_0008, 32'h0,         3'b010, 32'h1234_F00D, 0);
    add(0, 32'h1000_0008, 32'h0,         3'b101, 32'h0000_F00D, 0);
    add(0, 32'h0FFF_FFFC, 32'h0,         3'b010, 32'h0,         1);
    add(0, 32'h1000_03FC, 32'h0,         3'b011, 32'h0,         1);
    add(0, 32'h1000_0009, 32'h0,         3'b001, 32'h0,         1);
    add(0, 32'h1000_000A, 32'h0,         3'b001, 32'h0000_1234, 0);
    add(1, 32'h1000_03FC, 32'h7766_5544, 3'b010, 32'h0,         0);
    add(0, 32'h1000_03FF, 32'h0,         3'b000, 32'h0000_0077, 0);
    add(0, 32'h1000_0400, 32'h0,         3'b010, 32'h0,         1);
    for (int i = 0; i < nv; i++) begin
      txn(vt[i].w, vt[i].a, vt[i].d, vt[i].f, rd, e, lat);
      chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
      chk($sformatf("vec%0d_err", i), 32'(e), 32'(vt[i].exp_err));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
    end

    // Requests raised while busy must be dropped.
    txn(1, 32'h1000_0014, 32'h3333_3333, 3'b010, rd, e, lat);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h1000_0010; wdata = 32'h1111_1111; funct3 = 3'b010;
    nready = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) begin addr = 32'h1000_0014; wdata = 32'h2222_2222; end
      if (k == 3) req = 1'b0;
      nready += int'(ready1);
    end
    chk("busy_ignore_ready_count", 32'(nready), 32'd1);
    txn(0, 32'h1000_0014, 32'h0, 3'b010, rd, e, lat);
    chk("busy_ignore_target", rd, 32'h3333_3333);
    txn(0, 32'h1000_0010, 32'h0, 3'b010, rd, e, lat);
    chk("busy_first_store", rd, 32'h1111_1111);

    // Reset during WAIT aborts the store.
    txn(1, 32'h1000_0010, 32'h1234_5678, 3'b010, rd, e, lat);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h1000_0010; wdata = 32'hAAAA_AAAA; funct3 = 3'b010;
    @(negedge clk);
    req = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst_wait_outputs", {rdata1[29:0], ready1, err1}, 32'h0);
    chk("rst_wait_busy", 32'(busy1), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    nready = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      nready += int'(ready1);
    end
    chk("rst_wait_no_ready", 32'(nready), 32'd0);
    txn(0, 32'h1000_0010, 32'h0, 3'b010, rd, e, lat);
    chk("rst_wait_ram_kept", rd, 32'h1234_5678);

    // Reset during RESP: the write has already landed.
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h1000_0018; wdata = 32'h5A5A_5A5A; funct3 = 3'b010;
    @(negedge clk);
    req = 1'b0;
    for (int k = 1; k <= 20 && !ready1; k++) @(negedge clk);
    chk("rst_resp_reached", 32'(ready1), 32'h1);
    rst = 1'b0;
    #1;
    chk("rst_resp_ready_cleared", 32'(ready1), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    txn(0, 32'h1000_0018, 32'h0, 3'b010, rd, e, lat);
    chk("rst_resp_written", rd, 32'h5A5A_5A5A);

    // Bring the whole RAM to a known image, then randomized traffic against the model.
    for (int i = 0; i < Span / 4; i++) begin
      d = $urandom;
      model(1'b1, Base + 32'(4 * i), d, 3'b010, exp_rd, exp_e);
      txn(1'b1, Base + 32'(4 * i), d, 3'b010, rd, e, lat);
    end
    for (int n = 0; n < 400; n++) begin
      w = 1'($urandom_range(0, 1));
      f = 3'($urandom_range(0, 7));
      sz = (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : 4;
      case ($urandom_range(0, 15))
        0:       a = Base - 32'($urandom_range(1, 8));
        1:       a = Base + 32'(Span) + 32'($urandom_range(0, 7));
        default: a = Base + 32'($urandom_range(0, Span - 1));
      endcase
      if ($urandom_range(0, 3) != 0) a = a & ~32'(sz - 1);
      d = $urandom;
      model(w, a, d, f, exp_rd, exp_e);
      txn(w, a, d, f, rd, e, lat);
      chk($sformatf("rnd%0d_rdata a=%h f=%0d we=%0d", n, a, f, w), rd, exp_rd);
      chk($sformatf("rnd%0d_err", n), 32'(e), 32'(exp_e));
      chk($sformatf("rnd%0d_latency", n), 32'(lat), 32'd3);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_bus_responder.md
Name: data_bus_responder

Overview:
Memory-side responder for the CPU data bus. It serves load/store requests raised by the multi-cycle core's control path during its memory states.
- Accepts one request at a time.
- Inserts configurable wait states.
- Performs byte/half/word stores with lane merging.
- Returns sign- or zero-extended load data, plus a one-cycle ready/err response.
- Sits between the core's bus interface and a local word-organised data RAM.

Parameters:
ADDR_WIDTH, 8, word-address bits; RAM depth = 2^ADDR_WIDTH 32-bit words
BASE_ADDR, 32'h1000_0000, byte address of word 0; must be 4-byte aligned
WAIT_CYCLES, 1, wait states inserted between accept and access (0..15)

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  asynchronous reset, active-low (rst=0 resets)
req  input  1  request strobe; sampled only in IDLE
we  input  1  1 = store, 0 = load; sampled with req
addr  input  32  byte address; sampled with req
wdata  input  32  store data, right-aligned; sampled with req
funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
rdata  output  32  load result; valid only while ready=1
ready  output  1  one-cycle pulse, request completed
err  output  1  one-cycle pulse with ready, request rejected
busy  output  1  1 in any state other than IDLE

Behaviour:
- Reset (rst=0, async): state=IDLE; wait counter=0; rdata=0; ready=0; err=0; busy=0. RAM contents are not reset.
- FSM states: IDLE, WAIT, ACCESS, RESP.
- IDLE: if req=1, latch we/addr/wdata/funct3 and compute the error flag. Next state is WAIT if WAIT_CYCLES>0, else ACCESS.
- WAIT: counter counts 0..WAIT_CYCLES-1; on the last count, go to ACCESS.
- ACCESS: if no error, perform the RAM write (store) or word read (load); go to RESP.
- RESP: ready=1 for exactly one cycle. err and rdata are registered outputs. Return to IDLE.
- Latency: req high at edge N -> ready high during cycle N+WAIT_CYCLES+2. Back-to-back: next req is accepted in the cycle after RESP.
- req while busy=1 is ignored; it is neither queued nor latched.
- Error conditions (any one sets err):
  - funct3 in {011,110,111}.
  - Store with funct3 in {100,101}.
  - Half access with addr[0]=1.
  - Word access with addr[1:0]!=0.
  - addr < BASE_ADDR or addr >= BASE_ADDR + 4*2^ADDR_WIDTH.
- On error: no RAM write; rdata=0; err=1 alongside ready=1.
- Word index = (addr - BASE_ADDR) >> 2, truncated to ADDR_WIDTH bits after the range check.
- Stores use byte enables; unselected bytes keep their old value.
  - SB writes wdata[7:0] to lane addr[1:0].
  - SH writes wdata[15:0] to lanes {addr[1],0} and {addr[1],1}.
  - SW writes all four lanes.
- Loads:
  - LB/LBU: select byte lane addr[1:0]; sign- or zero-extend to 32 bits.
  - LH/LHU: select half addr[1]; extend likewise.
  - LW: full word.
- Stores: rdata=0 during RESP.
- Reset mid-operation: request aborted; ready/err are not pulsed for it.
  - Reset asserted before the ACCESS-exit edge: no RAM write.
  - Reset during RESP: the write has already happened.
- Simultaneous rst deassertion and req: req is honoured only on a clock edge where rst=1 and the state is IDLE.

Test Plan:
- WAIT_CYCLES=1: SW addr 0x1000_0004, wdata 0xDEADBEEF; then LW same addr -> each ready at cycle N+3, err=0, LW rdata=0xDEADBEEF.
- After the above: SB addr 0x1000_0007, wdata 0x0000_0080; LW 0x1000_0004 -> 0x80ADBEEF. LB 0x1000_0007 -> 0xFFFFFF80. LBU -> 0x00000080. LH 0x1000_0006 -> 0xFFFF80AD.
- LW addr 0x1000_0006 -> err=1, rdata=0. SW addr 0x1000_0402 with ADDR_WIDTH=8 -> err=1, and a following LW confirms RAM unchanged. SW with funct3=100 -> err=1.
- WAIT_CYCLES=0 and WAIT_CYCLES=3: req at cycle 0 -> ready exactly at cycle 2 and cycle 5 respectively; busy high from cycle 1 through the ready cycle.
- Second req pulsed while busy (SW different data/address) -> no second ready, target word unchanged.
- SW 0x1000_0010 of 0x12345678, then SW of 0xAAAAAAAA with rst pulsed low during WAIT -> outputs zero immediately, no ready pulse; subsequent LW returns 0x12345678.
